// File: rtl/rf_operand_fetch.sv
// Operand fetch unit: reads two source registers from a registered-read register file,
// covers the write-before-read hazard around the read, and snoops writebacks while holding.
module rf_operand_fetch #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_rs1,
    input  logic [AW-1:0]   req_rs2,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [XLEN-1:0] op_rs1_data,
    output logic [XLEN-1:0] op_rs2_data,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [AW-1:0]   rf_a1,
    output logic [AW-1:0]   rf_a2,
    output logic [AW-1:0]   rf_a3,
    output logic            rf_we,
    output logic [XLEN-1:0] rf_wd3,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [AW-1:0]   rs1_r;
    logic [AW-1:0]   rs2_r;
    logic            byp1_r;
    logic            byp2_r;
    logic [XLEN-1:0] byp1_data_r;
    logic [XLEN-1:0] byp2_data_r;
    logic [XLEN-1:0] op1_r;
    logic [XLEN-1:0] op2_r;
    logic            rf_we_s;
    logic            hit1_s;
    logic            hit2_s;

    // Operand source priority when the register file data arrives.
    function automatic logic [XLEN-1:0] pick_operand(
        input logic [AW-1:0]   idx,
        input logic            wb_hit,
        input logic [XLEN-1:0] wb_val,
        input logic            byp,
        input logic [XLEN-1:0] byp_val,
        input logic [XLEN-1:0] rf_val
    );
        logic [XLEN-1:0] res;
        if (idx == {AW{1'b0}}) begin
            res = {XLEN{1'b0}};
        end else if (wb_hit) begin
            res = wb_val;
        end else if (byp) begin
            res = byp_val;
        end else begin
            res = rf_val;
        end
        return res;
    endfunction

    // x0 writes are squashed here, so every hit below implies a nonzero index.
    assign rf_we_s = wb_valid && (wb_rd != {AW{1'b0}}) && !rst;
    assign hit1_s  = rf_we_s && (wb_rd == rs1_r);
    assign hit2_s  = rf_we_s && (wb_rd == rs2_r);

    assign rf_we       = rf_we_s;
    assign rf_a3       = wb_rd;
    assign rf_wd3      = wb_data;
    assign op_rs1_data = op1_r;
    assign op_rs2_data = op2_r;

    // Next-state logic and state-decoded handshake/address outputs.
    always_comb begin
        state_s   = state_r;
        req_ready = 1'b0;
        op_valid  = 1'b0;
        rf_a1     = {AW{1'b0}};
        rf_a2     = {AW{1'b0}};
        case (state_r)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                rf_a1   = rs1_r;
                rf_a2   = rs2_r;
                state_s = CAPTURE;
            end
            CAPTURE: begin
                state_s = HOLD;
            end
            HOLD: begin
                op_valid = 1'b1;
                if (op_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Index latch, read-cycle bypass capture, operand load and hold-time snoop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_r       <= {AW{1'b0}};
            rs2_r       <= {AW{1'b0}};
            byp1_r      <= 1'b0;
            byp2_r      <= 1'b0;
            byp1_data_r <= {XLEN{1'b0}};
            byp2_data_r <= {XLEN{1'b0}};
            op1_r       <= {XLEN{1'b0}};
            op2_r       <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        rs1_r  <= req_rs1;
                        rs2_r  <= req_rs2;
                        byp1_r <= 1'b0;
                        byp2_r <= 1'b0;
                    end
                end
                READ: begin
                    // The file returns the pre-write value for a same-edge write.
                    byp1_r      <= hit1_s;
                    byp2_r      <= hit2_s;
                    byp1_data_r <= wb_data;
                    byp2_data_r <= wb_data;
                end
                CAPTURE: begin
                    op1_r <= pick_operand(rs1_r, hit1_s, wb_data, byp1_r, byp1_data_r, rf_rd1);
                    op2_r <= pick_operand(rs2_r, hit2_s, wb_data, byp2_r, byp2_data_r, rf_rd2);
                end
                HOLD: begin
                    if (hit1_s) begin
                        op1_r <= wb_data;
                    end
                    if (hit2_s) begin
                        op2_r <= wb_data;
                    end
                end
                default: begin
                    byp1_r <= 1'b0;
                    byp2_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
